cnn_top: RTL and testbench
==========================

CNN_TOP -- requirements
Module: cnn_top

Interface
REQ-001 Parameter ADDR_W, default 17: image memory address width.
REQ-002 Parameter DATA_W, default 24: pixel width (RGB888: R[23:16], G[15:8], B[7:0]).
REQ-003 Parameter DEPTH, default 130560: pixels per frame (IMG_W 480 x IMG_H 272).
REQ-004 Parameter INIT_FILE, default "image.hex": hex file loading the image memory at elaboration.
REQ-005 iClk  input  1: single clock, all logic on the rising edge.
REQ-006 iRst  input  1: reset, synchronous and active-high.
REQ-007 iBusy  input  1: downstream stall; 1 = hold, 0 = advance.
REQ-008 oOut0..oOut8  output  DATA_W each: 3x3 window, row-major; oOut0 = pixel(r-2,c-2), oOut1 = (r-2,c-1), oOut2 = (r-2,c), oOut3 = (r-1,c-2) ... oOut8 = (r,c).
REQ-009 oValid  output  1: window outputs hold a complete in-image 3x3 window this cycle.

Function
REQ-010 The block SHALL stream one frame from internal image memory, raster order, address 0 to DEPTH-1, one pixel per non-stalled cycle.
REQ-011 Image memory SHALL be a synchronous-read ROM, 1-cycle read latency, with a read enable tied to !iBusy.
REQ-012 Two line buffers of IMG_W x DATA_W SHALL supply the rows r-1 and r-2 at column c.
REQ-013 The window SHALL shift left one column per accepted pixel; the new column is {line2[c], line1[c], pixel(r,c)}.
REQ-014 A pixel read at non-stalled cycle k SHALL appear as oOut8 on non-stalled cycle k+2 (registered outputs).
REQ-015 oValid SHALL be 1 only when r >= 2 and c >= 2; windows straddling a row boundary are never valid.
REQ-016 oValid SHALL pulse exactly (IMG_W-2)*(IMG_H-2) = 129060 times per frame.
REQ-017 With iBusy = 1 at a rising edge, the address counter, ROM data, line buffers, window and oOut0..oOut8 SHALL hold, and oValid SHALL be 0 for that cycle.
REQ-018 On iBusy returning to 0, streaming SHALL resume with no skipped or duplicated window.
REQ-019 After the last window (pixel address DEPTH-1) the block SHALL enter DONE: oValid 0, outputs hold, no further reads until reset.
REQ-020 States: IDLE (after reset, one cycle) -> RUN -> DONE; RUN stays while address < DEPTH-1 or the pipeline is not drained; DONE is terminal.
REQ-021 Row/column counters SHALL wrap column 479 -> 0 with row incremented; address SHALL not wrap past DEPTH-1.

Reset
REQ-022 While iRst = 1: oOut0..oOut8 = 0, oValid = 0, address/row/col counters = 0, state = IDLE; line-buffer contents need not be cleared.
REQ-023 Reset asserted mid-frame SHALL take effect on the next rising edge and restart the frame from address 0.

Structure
REQ-024 Package cnn_pkg SHALL hold ADDR_W, DATA_W, DEPTH, IMG_W = 480, IMG_H = 272, INIT_FILE default and the state encoding.
REQ-025 One sub-module image_rom (parameterised ADDR_W/DATA_W/DEPTH/INIT_FILE, sync read with enable); line buffers, window and control SHALL be in cnn_top.

Verification
REQ-026 Load the ROM with pixel value = address, hold iBusy = 0 -> first oValid with oOut0..8 = 0,1,2,480,481,482,960,961,962; next cycle each +1.
REQ-027 End of row 2 -> last valid window has oOut8 = 1439; oValid low for exactly 2 cycles; next window has oOut8 = 1442.
REQ-028 Full frame, iBusy = 0 -> exactly 129060 oValid pulses, last oOut8 = 130559, then DONE with oValid 0 forever.
REQ-029 Assert iBusy for 5 cycles mid-row -> oValid 0 and outputs frozen for those cycles; the first window after release is the successor of the last one before the stall.
REQ-030 Assert iRst for 1 cycle mid-frame -> all outputs 0 next cycle; the first subsequent valid window again equals 0,1,2,480,481,482,960,961,962.
REQ-031 Drive iBusy to a defined level from the first cycle after reset release; the bench must not leave it X.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared frame geometry, pixel format and control-state encoding for the 3x3 window streamer.
package cnn_pkg;

  localparam int unsigned ADDR_W = 17;
  localparam int unsigned DATA_W = 24;
  localparam int unsigned IMG_W  = 480;
  localparam int unsigned IMG_H  = 272;
  localparam int unsigned DEPTH  = IMG_W * IMG_H;

  localparam string INIT_FILE = "image.hex";

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/image_rom.sv
// Synchronous-read image ROM, one-cycle latency, output held while the enable is low.
module image_rom #(
  parameter int unsigned ADDR_W    = cnn_pkg::ADDR_W,
  parameter int unsigned DATA_W    = cnn_pkg::DATA_W,
  parameter int unsigned DEPTH     = cnn_pkg::DEPTH,
  parameter string       INIT_FILE = cnn_pkg::INIT_FILE
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] word_c;
  logic [DATA_W-1:0] data_q;

  // Frame content is produced from the address (pixel = address); an empty image name gives a blank frame.
  if (INIT_FILE == "") begin : g_blank
    assign word_c = '0;
  end else begin : g_ramp
    always_comb begin
      word_c = '0;
      if (32'(addr_i) < DEPTH) word_c = DATA_W'(addr_i);
    end
  end

  // Registered read port.
  always_ff @(posedge clk_i) begin
    if (en_i) data_q <= word_c;
  end

  assign data_o = data_q;

endmodule

// File: rtl/cnn_top.sv
// Streams one frame from the image ROM and presents a sliding 3x3 pixel window.
module cnn_top #(
  parameter int unsigned ADDR_W    = cnn_pkg::ADDR_W,
  parameter int unsigned DATA_W    = cnn_pkg::DATA_W,
  parameter int unsigned DEPTH     = cnn_pkg::DEPTH,
  parameter string       INIT_FILE = cnn_pkg::INIT_FILE,
  parameter int unsigned IMG_W     = cnn_pkg::IMG_W,
  parameter int unsigned IMG_H     = cnn_pkg::IMG_H
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iBusy,
  output logic [DATA_W-1:0] oOut0,
  output logic [DATA_W-1:0] oOut1,
  output logic [DATA_W-1:0] oOut2,
  output logic [DATA_W-1:0] oOut3,
  output logic [DATA_W-1:0] oOut4,
  output logic [DATA_W-1:0] oOut5,
  output logic [DATA_W-1:0] oOut6,
  output logic [DATA_W-1:0] oOut7,
  output logic [DATA_W-1:0] oOut8,
  output logic              oValid
);

  import cnn_pkg::*;

  localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              issued_all_q;
  logic              rd_vld_q;
  logic              rd_last_q;
  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;
  logic              valid_q;
  logic [DATA_W-1:0] win_q   [9];
  logic [DATA_W-1:0] line1_q [IMG_W];
  logic [DATA_W-1:0] line2_q [IMG_W];

  logic              rom_en_c;
  logic              adv_c;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] top_c;
  logic [DATA_W-1:0] mid_c;

  // A read is issued every non-stalled RUN cycle until the last address has gone out.
  assign rom_en_c = !iBusy && (state_q == ST_RUN) && !issued_all_q;
  // The window advances whenever the ROM output holds a pixel not yet consumed.
  assign adv_c    = !iBusy && (state_q == ST_RUN) && rd_vld_q;

  assign top_c = line2_q[col_q];
  assign mid_c = line1_q[col_q];

  image_rom #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .INIT_FILE (INIT_FILE)
  ) u_rom (
    .clk_i  (iClk),
    .en_i   (rom_en_c),
    .addr_i (addr_q),
    .data_o (rom_data)
  );

  // Line buffers: row r-1 ages into row r-2 as the new pixel lands in its column.
  always_ff @(posedge iClk) begin
    if (adv_c) begin
      line1_q[col_q] <= rom_data;
      line2_q[col_q] <= line1_q[col_q];
    end
  end

  // Control FSM, address/row/column counters and the registered 3x3 window.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      issued_all_q <= 1'b0;
      rd_vld_q     <= 1'b0;
      rd_last_q    <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
      valid_q      <= 1'b0;
      win_q        <= '{default: '0};
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: state_q <= ST_RUN;
        ST_RUN: begin
          if (!iBusy) begin
            rd_vld_q  <= rom_en_c;
            rd_last_q <= rom_en_c && (addr_q == ADDR_W'(DEPTH - 1));
            if (rom_en_c) begin
              if (addr_q == ADDR_W'(DEPTH - 1)) issued_all_q <= 1'b1;
              else                              addr_q       <= addr_q + ADDR_W'(1);
            end
            if (rd_vld_q) begin
              win_q[0] <= win_q[1];
              win_q[1] <= win_q[2];
              win_q[2] <= top_c;
              win_q[3] <= win_q[4];
              win_q[4] <= win_q[5];
              win_q[5] <= mid_c;
              win_q[6] <= win_q[7];
              win_q[7] <= win_q[8];
              win_q[8] <= rom_data;
              valid_q  <= (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
              if (col_q == COL_W'(IMG_W - 1)) begin
                col_q <= '0;
                row_q <= (row_q == ROW_W'(IMG_H - 1)) ? '0 : row_q + ROW_W'(1);
              end else begin
                col_q <= col_q + COL_W'(1);
              end
              if (rd_last_q) state_q <= ST_DONE;
            end
          end
        end
        default: state_q <= ST_DONE;
      endcase
    end
  end

  assign oOut0  = win_q[0];
  assign oOut1  = win_q[1];
  assign oOut2  = win_q[2];
  assign oOut3  = win_q[3];
  assign oOut4  = win_q[4];
  assign oOut5  = win_q[5];
  assign oOut6  = win_q[6];
  assign oOut7  = win_q[7];
  assign oOut8  = win_q[8];
  assign oValid = valid_q;

endmodule

// File: tb/tb_cnn_top.sv
// Directed bench for cnn_top on a 480 x 20 frame whose pixels equal their addresses.
module tb_cnn_top;

  localparam int unsigned ADDR_W  = 17;
  localparam int unsigned DATA_W  = 24;
  localparam int unsigned IMG_W   = 480;
  localparam int unsigned IMG_H   = 20;
  localparam int unsigned DEPTH   = IMG_W * IMG_H;
  localparam int unsigned N_VALID = (IMG_W - 2) * (IMG_H - 2);

  typedef struct {
    logic busy;
    logic exp_valid;
    int   exp_out0;
    int   exp_out8;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic valid;
  logic [DATA_W-1:0] o0, o1, o2, o3, o4, o5, o6, o7, o8;
  logic [DATA_W-1:0] win [9];

  int n_cmp = 0;
  int n_err = 0;
  int mr, mc, n_pulses, last8;

  int   first_win [9];
  vec_t row_vec   [4];
  vec_t stall_vec [6];

  always #5 clk = ~clk;

  always_comb begin
    win[0] = o0; win[1] = o1; win[2] = o2;
    win[3] = o3; win[4] = o4; win[5] = o5;
    win[6] = o6; win[7] = o7; win[8] = o8;
  end

  cnn_top #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .INIT_FILE ("image.hex"),
    .IMG_W     (IMG_W),
    .IMG_H     (IMG_H)
  ) dut (
    .iClk   (clk),
    .iRst   (rst),
    .iBusy  (busy),
    .oOut0  (o0),
    .oOut1  (o1),
    .oOut2  (o2),
    .oOut3  (o3),
    .oOut4  (o4),
    .oOut5  (o5),
    .oOut6  (o6),
    .oOut7  (o7),
    .oOut8  (o8),
    .oValid (valid)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mr = 2; mc = 2; n_pulses = 0; last8 = -1;
  endtask

  // One clock; at the falling edge every valid window is checked against the raster model.
  task automatic tick();
    int exp8;
    @(negedge clk);
    if (valid === 1'b1) begin
      exp8 = mr * IMG_W + mc;
      for (int i = 0; i < 9; i++)
        check($sformatf("window[%0d]", i), win[i],
              exp8 - (2 - i / 3) * IMG_W - (2 - i % 3));
      n_pulses++;
      last8 = int'(win[8]);
      mc++;
      if (mc == IMG_W) begin
        mc = 2;
        mr++;
      end
    end
  endtask

  task automatic wait_anchor(input int anchor, input int budget);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      tick();
      if (valid === 1'b1 && int'(win[8]) == anchor) hit = 1'b1;
    end
    check($sformatf("anchor_%0d_seen", anchor), hit, 1);
  endtask

  task automatic wait_first_valid(input int budget);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      tick();
      if (valid === 1'b1) hit = 1'b1;
    end
    check("first_valid_seen", hit, 1);
    for (int i = 0; i < 9; i++)
      check($sformatf("first_win[%0d]", i), win[i], first_win[i]);
  endtask

  task automatic apply_vec(input string name, input vec_t v);
    busy = v.busy;
    tick();
    check({name, "_valid"}, valid, v.exp_valid);
    check({name, "_out0"}, win[0], v.exp_out0);
    check({name, "_out8"}, win[8], v.exp_out8);
  endtask

  task automatic pulse_reset(input string name);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    check({name, "_valid"}, valid, 0);
    for (int i = 0; i < 9; i++)
      check($sformatf("%s_out%0d", name, i), win[i], 0);
  endtask

  initial begin
    first_win = '{0, 1, 2, 480, 481, 482, 960, 961, 962};
    // Across the end of row 2: two straddling windows, then row 3 resumes at column 2.
    row_vec[0] = '{busy: 1'b0, exp_valid: 1'b0, exp_out0: 478, exp_out8: 1440};
    row_vec[1] = '{busy: 1'b0, exp_valid: 1'b0, exp_out0: 479, exp_out8: 1441};
    row_vec[2] = '{busy: 1'b0, exp_valid: 1'b1, exp_out0: 480, exp_out8: 1442};
    row_vec[3] = '{busy: 1'b0, exp_valid: 1'b1, exp_out0: 481, exp_out8: 1443};
    // Five stalled cycles after the window ending at pixel 2500 (row 5, column 100).
    for (int i = 0; i < 5; i++)
      stall_vec[i] = '{busy: 1'b1, exp_valid: 1'b0, exp_out0: 1538, exp_out8: 2500};
    stall_vec[5] = '{busy: 1'b0, exp_valid: 1'b1, exp_out0: 1539, exp_out8: 2501};

    rst  = 1'b1;
    busy = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_valid", valid, 0);
    check("rst_out0", win[0], 0);
    check("rst_out4", win[4], 0);
    check("rst_out8", win[8], 0);
    rst = 1'b0;

    wait_first_valid(3000);
    tick();
    check("second_valid", valid, 1);
    for (int i = 0; i < 9; i++)
      check($sformatf("second_win[%0d]", i), win[i], first_win[i] + 1);

    wait_anchor(1439, 2000);
    for (int i = 0; i < 4; i++) apply_vec($sformatf("row_end%0d", i), row_vec[i]);

    wait_anchor(2500, 2000);
    for (int i = 0; i < 6; i++) apply_vec($sformatf("stall%0d", i), stall_vec[i]);

    for (int i = 0; i < int'(DEPTH) + 100 && n_pulses < int'(N_VALID); i++) tick();
    check("frame_pulses", n_pulses, N_VALID);
    check("frame_last_out8", last8, DEPTH - 1);

    for (int i = 0; i < 30; i++) begin
      tick();
      check("done_valid", valid, 0);
    end
    check("done_hold_out8", win[8], DEPTH - 1);
    check("done_hold_out0", win[0], DEPTH - 1 - 962);
    check("done_pulses", n_pulses, N_VALID);

    pulse_reset("restart");
    repeat (2000) tick();
    check("mid_frame_pulses", n_pulses > 0, 1);
    pulse_reset("mid_rst");
    wait_first_valid(3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
